// File: rtl/user_au_pkg.sv
// Shared types, constants and helpers for the user audio effect blocks.
package user_au_pkg;

    // Control states of the echo engine
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CALC  = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // Signed 16-bit audio sample
    typedef logic signed [15:0] sample_t;

    localparam sample_t SampleMax = 16'sh7FFF;
    localparam sample_t SampleMin = 16'sh8000;

    // Clamp an 18-bit signed intermediate into the 16-bit sample range
    function automatic sample_t sat16(input logic signed [17:0] v);
        sample_t r;
        if (v > 18'sh07FFF) begin
            r = SampleMax;
        end else if (v < 18'sh38000) begin
            r = SampleMin;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/user_au_delay_mem.sv
// Single-port delay-line RAM: synchronous write, registered read (1-cycle latency).
// Storage is deliberately not reset; the owner zeroes it by sweeping writes.
module user_au_delay_mem
    import user_au_pkg::*;
#(
    parameter int Depth = 256,
    parameter int AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  logic [15:0]      wdata_i,
    output logic [15:0]      rdata_o
);

    sample_t mem_q [Depth];
    sample_t rdata_q;

    // Write port and registered read of the addressed entry
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/user_au_echo.sv
// Single-tap echo: y = sat16(x + (delayed >>> MixShift)), fed back into a
// circular delay line of programmable length. One sample per 3 cycles max.
module user_au_echo
    import user_au_pkg::*;
#(
    parameter int DelayLen = 256,
    parameter int MixShift = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [31:0]               data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [31:0]               data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    input  logic [$clog2(DelayLen):0] delay_len_i,
    input  logic                      bypass_i
);

    localparam int AddrW = $clog2(DelayLen);
    localparam int LenW  = AddrW + 1;

    state_e            state_q,   state_d;
    logic [AddrW-1:0]  clr_cnt_q, clr_cnt_d;
    logic [AddrW-1:0]  wr_ptr_q,  wr_ptr_d;
    sample_t           x_q,       x_d;
    logic [LenW-1:0]   len_q,     len_d;
    logic              byp_q,     byp_d;
    logic [31:0]       data_q,    data_d;
    logic              valid_q,   valid_d;
    logic              ready_q,   ready_d;

    logic              mem_we_s;
    logic [AddrW-1:0]  mem_addr_s;
    logic [15:0]       mem_wdata_s;
    logic [15:0]       mem_rdata_s;

    logic [LenW-1:0]   eff_len_s;
    logic [LenW-1:0]   ptr_inc_s;
    logic [AddrW-1:0]  ptr_next_s;
    sample_t           d_s;
    sample_t           d_shift_s;
    logic signed [17:0] sum_s;
    sample_t           y_s;
    logic              unused_upper_s;

    // Only the low half of the input word carries the sample
    assign unused_upper_s = ^data_i[31:16];

    user_au_delay_mem #(
        .Depth (DelayLen),
        .AddrW (AddrW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we_s),
        .addr_i  (mem_addr_s),
        .wdata_i (mem_wdata_s),
        .rdata_o (mem_rdata_s)
    );

    // Clamp the requested delay into 1..DelayLen
    always_comb begin
        eff_len_s = delay_len_i;
        if (delay_len_i == {LenW{1'b0}}) begin
            eff_len_s = LenW'(1);
        end else if (delay_len_i > LenW'(DelayLen)) begin
            eff_len_s = LenW'(DelayLen);
        end else begin
            eff_len_s = delay_len_i;
        end
    end

    // Pointer advance; also recovers a pointer left beyond a shortened length
    always_comb begin
        ptr_inc_s  = {1'b0, wr_ptr_q} + LenW'(1);
        ptr_next_s = ptr_inc_s[AddrW-1:0];
        if (ptr_inc_s >= len_q) begin
            ptr_next_s = {AddrW{1'b0}};
        end else begin
            ptr_next_s = ptr_inc_s[AddrW-1:0];
        end
    end

    // Echo mix datapath with 18-bit headroom before saturation
    always_comb begin
        d_s       = mem_rdata_s;
        d_shift_s = d_s >>> MixShift;
        sum_s     = {{2{x_q[15]}}, x_q} + {{2{d_shift_s[15]}}, d_shift_s};
        y_s       = sat16(sum_s);
    end

    // Next-state, memory control and output decode
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        x_d         = x_q;
        len_d       = len_q;
        byp_d       = byp_q;
        data_d      = data_q;
        mem_we_s    = 1'b0;
        mem_addr_s  = wr_ptr_q;
        mem_wdata_s = 16'h0000;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = clr_cnt_q;
                mem_wdata_s = 16'h0000;
                if (clr_cnt_q == AddrW'(DelayLen - 1)) begin
                    clr_cnt_d = {AddrW{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + AddrW'(1);
                end
            end
            ST_IDLE: begin
                // Read at wr_ptr is issued here so data is ready in CALC
                if (valid_i && ready_q) begin
                    x_d     = data_i[15:0];
                    len_d   = eff_len_s;
                    byp_d   = bypass_i;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (byp_q) begin
                    data_d = {{16{x_q[15]}}, x_q};
                end else begin
                    mem_we_s    = 1'b1;
                    mem_wdata_s = y_s;
                    wr_ptr_d    = ptr_next_s;
                    data_d      = {{16{y_s[15]}}, y_s};
                end
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_OUT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= {AddrW{1'b0}};
            wr_ptr_q  <= {AddrW{1'b0}};
            x_q       <= 16'sh0000;
            len_q     <= LenW'(1);
            byp_q     <= 1'b0;
            data_q    <= 32'h0000_0000;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            x_q       <= x_d;
            len_q     <= len_d;
            byp_q     <= byp_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_user_au_echo.sv
// Directed self-checking bench for user_au_echo (DelayLen=8, MixShift=1).
module tb_user_au_echo;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic [3:0]  delay_len_i;
    logic        bypass_i;

    int vecs = 0;
    int errs = 0;

    always #5 clk_i = ~clk_i;

    user_au_echo #(
        .DelayLen (8),
        .MixShift (1)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .delay_len_i (delay_len_i),
        .bypass_i    (bypass_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Hold reset, release it, then expect exactly 8 not-ready cycles
    task automatic do_reset;
        rst_i   = 1'b1;
        valid_i = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_data", data_o, 32'h0000_0000);
        rst_i = 1'b0;
        chk("clr_ready0", {31'd0, ready_o}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("clr_ready", {31'd0, ready_o}, 32'd0);
            chk("clr_valid", {31'd0, valid_o}, 32'd0);
        end
        tick();
        chk("clr_done_ready", {31'd0, ready_o}, 32'd1);
    endtask

    // Wait (bounded) for ready, accept one sample, check fixed 2-cycle latency
    task automatic send(input logic [31:0] din, input logic [31:0] exp, input string tag);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        data_i  = din;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        chk({tag, "_t1"}, {31'd0, valid_o}, 32'd0);
        tick();
        chk({tag, "_t2"}, {31'd0, valid_o}, 32'd1);
        chk({tag, "_data"}, data_o, exp);
        if (ready_i) begin
            tick();
        end
    endtask

    logic [31:0] imp_exp [9];

    initial begin
        rst_i       = 1'b1;
        data_i      = 32'h0;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        delay_len_i = 4'd4;
        bypass_i    = 1'b0;

        // Reset and clear sweep
        do_reset();

        // Impulse with L=4: echo halves every 4 samples
        imp_exp = '{32'h1000, 32'h0, 32'h0, 32'h0, 32'h0800, 32'h0, 32'h0, 32'h0, 32'h0400};
        for (int i = 0; i < 9; i++) begin
            send((i == 0) ? 32'h0000_1000 : 32'h0, imp_exp[i], "imp4");
        end

        // L=1 positive saturation
        do_reset();
        delay_len_i = 4'd1;
        send(32'h0000_7000, 32'h0000_7000, "pos1");
        send(32'h0000_7000, 32'h0000_7FFF, "pos2");

        // L=1 negative saturation
        do_reset();
        send(32'hFFFF_8000, 32'hFFFF_8000, "neg1");
        send(32'hFFFF_8000, 32'hFFFF_8000, "neg2");

        // Length 0 behaves as 1
        do_reset();
        delay_len_i = 4'd0;
        send(32'h0000_7000, 32'h0000_7000, "len0a");
        send(32'h0000_7000, 32'h0000_7FFF, "len0b");

        // Length above DelayLen saturates to 8
        do_reset();
        delay_len_i = 4'd15;
        send(32'h0000_2000, 32'h0000_2000, "len15_imp");
        for (int i = 0; i < 7; i++) begin
            send(32'h0, 32'h0, "len15_z");
        end
        send(32'h0, 32'h0000_1000, "len15_echo");

        // Downstream stall holds output
        do_reset();
        delay_len_i = 4'd4;
        ready_i = 1'b0;
        send(32'h0000_0123, 32'h0000_0123, "stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, valid_o}, 32'd1);
            chk("stall_data", data_o, 32'h0000_0123);
            chk("stall_ready", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        tick();
        chk("stall_rel_ready", {31'd0, ready_o}, 32'd1);
        chk("stall_rel_valid", {31'd0, valid_o}, 32'd0);
        chk("stall_hold_data", data_o, 32'h0000_0123);

        // Bypass sample mid-stream leaves pointer and echo untouched
        do_reset();
        delay_len_i = 4'd4;
        send(32'h0000_1000, 32'h0000_1000, "byp_imp");
        send(32'h0, 32'h0, "byp_z1");
        bypass_i = 1'b1;
        send(32'h0000_1234, 32'h0000_1234, "byp_pass");
        bypass_i = 1'b0;
        send(32'h0, 32'h0, "byp_z2");
        send(32'h0, 32'h0, "byp_z3");
        send(32'h0, 32'h0000_0800, "byp_echo");

        // Reset during OUT discards sample and clears stale history
        do_reset();
        send(32'h0000_1000, 32'h0000_1000, "mr_fill");
        ready_i = 1'b0;
        send(32'h0, 32'h0, "mr_pend");
        rst_i = 1'b1;
        tick();
        chk("mr_valid_drop", {31'd0, valid_o}, 32'd0);
        chk("mr_ready", {31'd0, ready_o}, 32'd0);
        ready_i = 1'b1;
        do_reset();
        send(32'h0000_0100, 32'h0000_0100, "mr_imp");
        send(32'h0, 32'h0, "mr_z1");
        send(32'h0, 32'h0, "mr_z2");
        send(32'h0, 32'h0, "mr_z3");
        send(32'h0, 32'h0000_0080, "mr_echo");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
